// File: rtl/inst_sram_axi_bridge_pkg.sv
// Shared constants for the instruction SRAM-to-AXI read bridge:
// AXI burst/size codes and the AR channel FSM encodings.
package inst_sram_axi_bridge_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [2:0] AXI_SIZE_1B = 3'd0;
   localparam logic [2:0] AXI_SIZE_2B = 3'd1;
   localparam logic [2:0] AXI_SIZE_4B = 3'd2;

   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

   localparam logic [0:0] AR_IDLE = 1'b0;
   localparam logic [0:0] AR_SEND = 1'b1;

endpackage

// File: rtl/inst_sram_axi_bridge.sv
// Bridges the IF stage's SRAM-like inst_sram read port onto single-beat
// AXI4 AR/R transactions, tracking accepted requests so replies stay in order.
module inst_sram_axi_bridge
   import inst_sram_axi_bridge_pkg::*;
#(
   parameter int         MAX_OUTST = 2,
   parameter logic [3:0] AXI_ID    = 4'd0
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,

   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,

   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   localparam int             CW      = $clog2(MAX_OUTST + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTST);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);

   logic [0:0]    state;
   logic [CW-1:0] outst_cnt;
   logic [31:0]   araddr_q;
   logic [2:0]    arsize_q;

   // Write-side inputs, ID and response code are intentionally unused:
   // the port is read-only and a single ID keeps responses in order.
   logic unused_inputs;
   assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                            rid, rresp, rlast};

   assign inst_sram_addr_ok = (state == AR_IDLE) && inst_sram_req &&
                              (outst_cnt < CNT_MAX);
   assign inst_sram_data_ok = rvalid;
   assign inst_sram_rdata   = rdata;

   assign arid    = AXI_ID;
   assign araddr  = araddr_q;
   assign arlen   = AXI_LEN_SINGLE;
   assign arsize  = arsize_q;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;
   assign arvalid = (state == AR_SEND);
   assign rready  = 1'b1;

   // AR FSM: capture the request on addr_ok, then hold it until arready.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= AR_IDLE;
         araddr_q <= '0;
         arsize_q <= '0;
      end else begin
         unique case (state)
            AR_IDLE: begin
               if (inst_sram_addr_ok) begin
                  state    <= AR_SEND;
                  araddr_q <= inst_sram_addr;
                  arsize_q <= {1'b0, inst_sram_size};
               end
            end
            AR_SEND: begin
               if (arready) begin
                  state <= AR_IDLE;
               end
            end
         endcase
      end
   end

   // Outstanding counter: accepted requests not yet answered on R.
   always_ff @(posedge clk) begin
      if (reset) begin
         outst_cnt <= '0;
      end else begin
         unique case ({inst_sram_addr_ok, inst_sram_data_ok})
            2'b10:   outst_cnt <= outst_cnt + CNT_ONE;
            2'b01:   outst_cnt <= outst_cnt - CNT_ONE;
            default: outst_cnt <= outst_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Self-checking bench for inst_sram_axi_bridge: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_inst_sram_axi_bridge;

   localparam int         MAXO = 2;
   localparam logic [3:0] ID   = 4'd0;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   inst_sram_axi_bridge #(.MAX_OUTST(MAXO), .AXI_ID(ID)) dut (
      .clk               (clk),
      .reset             (reset),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .arid              (arid),
      .araddr            (araddr),
      .arlen             (arlen),
      .arsize            (arsize),
      .arburst           (arburst),
      .arlock            (arlock),
      .arcache           (arcache),
      .arprot            (arprot),
      .arvalid           (arvalid),
      .arready           (arready),
      .rid               (rid),
      .rdata             (rdata),
      .rresp             (rresp),
      .rlast             (rlast),
      .rvalid            (rvalid),
      .rready            (rready)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a ^ 32'h1234_5678;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      inst_sram_req   = 1'b0;
      inst_sram_wr    = 1'b0;
      inst_sram_size  = 2'd2;
      inst_sram_wstrb = 4'h0;
      inst_sram_addr  = 32'h0;
      inst_sram_wdata = 32'h0;
      arready = 1'b0;
      rid     = 4'h0;
      rdata   = 32'h0;
      rresp   = 2'b00;
      rlast   = 1'b1;
      rvalid  = 1'b0;
   endtask

   task automatic test_reset();
      logic [30:0] k;
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
      mid();
      n_run++;
      if (arvalid !== 1'b0) begin
         n_fail++; $display("FAIL reset_arvalid got %b exp 0", arvalid);
      end
      n_run++;
      if ({inst_sram_addr_ok, inst_sram_data_ok} !== 2'b00) begin
         n_fail++; $display("FAIL reset_ok got %b%b exp 00",
                            inst_sram_addr_ok, inst_sram_data_ok);
      end
      n_run++;
      if ({araddr, arsize} !== 35'h0) begin
         n_fail++; $display("FAIL reset_arregs got %h/%h exp 0/0", araddr, arsize);
      end
      k = {ID, 8'd0, 2'b01, 2'b00, 4'h0, 3'b000, 1'b1, 7'd0};
      n_run++;
      if ({arid, arlen, arburst, arlock, arcache, arprot, rready, 7'd0} !== k) begin
         n_fail++; $display("FAIL const_ar got %h exp %h",
            {arid, arlen, arburst, arlock, arcache, arprot, rready, 7'd0}, k);
      end
   endtask

   task automatic test_single_read();
      tick();
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0000;
      inst_sram_size = 2'd2;
      mid();
      n_run++;
      if (inst_sram_addr_ok !== 1'b1) begin
         n_fail++; $display("FAIL single_addr_ok got %b exp 1", inst_sram_addr_ok);
      end
      tick();
      inst_sram_req = 1'b0;
      mid();
      n_run++;
      if ({arvalid, araddr, arsize, arlen, inst_sram_addr_ok} !==
          {1'b1, 32'h1C00_0000, 3'd2, 8'd0, 1'b0}) begin
         n_fail++; $display("FAIL single_ar got v=%b a=%h s=%0d l=%0d exp 1 1c000000 2 0",
                            arvalid, araddr, arsize, arlen);
      end
      tick();
      arready = 1'b1;
      mid();
      tick();
      arready = 1'b0;
      mid();
      n_run++;
      if (arvalid !== 1'b0) begin
         n_fail++; $display("FAIL single_ar_done got %b exp 0", arvalid);
      end
      tick();
      tick();
      rvalid = 1'b1;
      rdata  = 32'h0280_0000;
      mid();
      n_run++;
      if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'h0280_0000}) begin
         n_fail++; $display("FAIL single_data got %b/%h exp 1/02800000",
                            inst_sram_data_ok, inst_sram_rdata);
      end
      tick();
      rvalid = 1'b0;
      mid();
      n_run++;
      if (inst_sram_data_ok !== 1'b0) begin
         n_fail++; $display("FAIL single_data_end got %b exp 0", inst_sram_data_ok);
      end
   endtask

   task automatic test_backpressure();
      tick();
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0040;
      inst_sram_size = 2'd1;
      mid();
      tick();
      inst_sram_addr = 32'h1C00_0044;
      inst_sram_size = 2'd2;
      for (int i = 0; i < 5; i++) begin
         mid();
         n_run++;
         if ({arvalid, araddr, arsize, inst_sram_addr_ok} !==
             {1'b1, 32'h1C00_0040, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL bp_hold%0d got v=%b a=%h s=%0d aok=%b", i,
                               arvalid, araddr, arsize, inst_sram_addr_ok);
         end
         if (i < 4) tick();
      end
      tick();
      arready = 1'b1;
      mid();
      tick();
      arready = 1'b0;
      mid();
      n_run++;
      if ({arvalid, inst_sram_addr_ok} !== 2'b01) begin
         n_fail++; $display("FAIL bp_fire got v=%b aok=%b exp 0 1",
                            arvalid, inst_sram_addr_ok);
      end
      tick();
      inst_sram_req = 1'b0;
      arready = 1'b1;
      mid();
      tick();
      arready = 1'b0;
      rvalid  = 1'b1;
      rdata   = 32'hAAAA_0001;
      mid();
      tick();
      rdata = 32'hAAAA_0002;
      mid();
      n_run++;
      if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'hAAAA_0002}) begin
         n_fail++; $display("FAIL bp_data got %b/%h exp 1/aaaa0002",
                            inst_sram_data_ok, inst_sram_rdata);
      end
      tick();
      rvalid = 1'b0;
   endtask

   task automatic test_outstanding_limit();
      int  pulses;
      logic a;
      pulses = 0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0100;
      arready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mid();
         a = inst_sram_addr_ok;
         if (a) pulses++;
         tick();
         if (a) inst_sram_addr = inst_sram_addr + 32'd4;
      end
      mid();
      n_run++;
      if (pulses != 2 || inst_sram_addr_ok !== 1'b0) begin
         n_fail++; $display("FAIL limit_pulses got %0d aok=%b exp 2 0",
                            pulses, inst_sram_addr_ok);
      end
      tick();
      rvalid = 1'b1;
      rdata  = 32'h0000_0BAD;
      mid();
      n_run++;
      if ({inst_sram_data_ok, inst_sram_addr_ok} !== 2'b10) begin
         n_fail++; $display("FAIL limit_rsp got dok=%b aok=%b exp 1 0",
                            inst_sram_data_ok, inst_sram_addr_ok);
      end
      tick();
      rvalid = 1'b0;
      mid();
      n_run++;
      if (inst_sram_addr_ok !== 1'b1) begin
         n_fail++; $display("FAIL limit_third got %b exp 1", inst_sram_addr_ok);
      end
      tick();
      inst_sram_req = 1'b0;
      tick();
      rvalid = 1'b1;
      tick();
      tick();
      rvalid  = 1'b0;
      arready = 1'b0;
   endtask

   task automatic test_req_drop();
      tick();
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0200;
      mid();
      tick();
      inst_sram_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid();
         n_run++;
         if ({arvalid, araddr} !== {1'b1, 32'h1C00_0200}) begin
            n_fail++; $display("FAIL drop_hold%0d got %b/%h exp 1/1c000200",
                               i, arvalid, araddr);
         end
         tick();
      end
      arready = 1'b1;
      mid();
      tick();
      arready = 1'b0;
      rvalid  = 1'b1;
      rdata   = 32'h0000_D0D0;
      mid();
      n_run++;
      if ({arvalid, inst_sram_data_ok, inst_sram_rdata} !==
          {1'b0, 1'b1, 32'h0000_D0D0}) begin
         n_fail++; $display("FAIL drop_data got v=%b dok=%b d=%h exp 0 1 0000d0d0",
                            arvalid, inst_sram_data_ok, inst_sram_rdata);
      end
      tick();
      rvalid = 1'b0;
   endtask

   task automatic test_simultaneous();
      tick();
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0300;
      mid();
      tick();
      inst_sram_req = 1'b0;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0304;
      rvalid = 1'b1;
      mid();
      n_run++;
      if ({inst_sram_addr_ok, inst_sram_data_ok} !== 2'b11) begin
         n_fail++; $display("FAIL simul_both got aok=%b dok=%b exp 1 1",
                            inst_sram_addr_ok, inst_sram_data_ok);
      end
      tick();
      inst_sram_req = 1'b0;
      rvalid  = 1'b0;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0308;
      mid();
      n_run++;
      if (inst_sram_addr_ok !== 1'b1) begin
         n_fail++; $display("FAIL simul_cnt1 got aok=%b exp 1", inst_sram_addr_ok);
      end
      tick();
      inst_sram_req = 1'b0;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_030C;
      mid();
      n_run++;
      if (inst_sram_addr_ok !== 1'b0) begin
         n_fail++; $display("FAIL simul_cnt2 got aok=%b exp 0", inst_sram_addr_ok);
      end
      tick();
      inst_sram_req = 1'b0;
      rvalid = 1'b1;
      tick();
      tick();
      rvalid = 1'b0;
   endtask

   task automatic test_reset_mid();
      tick();
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0400;
      mid();
      tick();
      inst_sram_req = 1'b0;
      mid();
      n_run++;
      if (arvalid !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_send got %b exp 1", arvalid);
      end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0500;
      mid();
      n_run++;
      if ({arvalid, araddr, inst_sram_addr_ok} !== {1'b0, 32'h0, 1'b1}) begin
         n_fail++; $display("FAIL rstmid_clear got v=%b a=%h aok=%b exp 0 0 1",
                            arvalid, araddr, inst_sram_addr_ok);
      end
      tick();
      inst_sram_req = 1'b0;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1C00_0504;
      mid();
      n_run++;
      if (inst_sram_addr_ok !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_cnt got aok=%b exp 1", inst_sram_addr_ok);
      end
      tick();
      inst_sram_req = 1'b0;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid  = 1'b1;
      tick();
      tick();
      rvalid = 1'b0;
   endtask

   task automatic test_random();
      bit          busy;
      bit          hold;
      bit          exp_aok;
      int          outst;
      logic [31:0] b_addr;
      logic [2:0]  b_size;
      logic [31:0] rq[$];
      int          bad_aok, bad_ar, bad_r, bad_uf;
      busy = 0; hold = 0; outst = 0;
      b_addr = '0; b_size = '0;
      bad_aok = 0; bad_ar = 0; bad_r = 0; bad_uf = 0;
      reset = 1'b1;
      idle_inputs();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!hold) begin
            inst_sram_req  = ($urandom_range(0, 1) == 1);
            inst_sram_addr = $urandom() & 32'hFFFF_FFFC;
            inst_sram_size = 2'($urandom_range(0, 2));
         end
         inst_sram_wr    = 1'($urandom());
         inst_sram_wstrb = 4'($urandom());
         inst_sram_wdata = $urandom();
         arready = ($urandom_range(0, 2) != 0);
         rvalid  = (rq.size() > 0) && ($urandom_range(0, 2) == 0);
         rdata   = rvalid ? mem_word(rq[0]) : $urandom();
         rid     = 4'($urandom());
         rresp   = 2'($urandom());
         mid();
         exp_aok = inst_sram_req && !busy && (outst < MAXO);
         n_run++;
         if (inst_sram_addr_ok !== exp_aok) begin
            n_fail++;
            if (bad_aok++ < 5)
               $display("FAIL rnd_addr_ok c=%0d got %b exp %b", c,
                        inst_sram_addr_ok, exp_aok);
         end
         n_run++;
         if (arvalid !== busy || (busy && {araddr, arsize} !== {b_addr, b_size})) begin
            n_fail++;
            if (bad_ar++ < 5)
               $display("FAIL rnd_ar c=%0d got %b/%h/%0d exp %b/%h/%0d", c,
                        arvalid, araddr, arsize, busy, b_addr, b_size);
         end
         n_run++;
         if (inst_sram_data_ok !== rvalid ||
             (rvalid && inst_sram_rdata !== mem_word(rq[0]))) begin
            n_fail++;
            if (bad_r++ < 5)
               $display("FAIL rnd_r c=%0d got %b/%h exp %b", c,
                        inst_sram_data_ok, inst_sram_rdata, rvalid);
         end
         n_run++;
         if (rvalid && outst == 0) begin
            n_fail++;
            if (bad_uf++ < 5)
               $display("FAIL rnd_underflow c=%0d got cnt 0 exp >0", c);
         end
         if (busy && arready) begin
            busy = 0;
            rq.push_back(b_addr);
         end
         if (exp_aok) begin
            busy   = 1;
            b_addr = inst_sram_addr;
            b_size = {1'b0, inst_sram_size};
         end
         outst = outst + int'(exp_aok) - int'(rvalid);
         if (rvalid) void'(rq.pop_front());
         hold = inst_sram_req && !exp_aok;
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_backpressure();
      test_outstanding_limit();
      test_req_drop();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
